alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Multi-cycle control unit for the 4-bit ALU.
- Fetches 12-bit instructions from an external ROM and decodes them.
- Drives ALU opcode and register-file read addresses, then writes results back to a 4x4-bit register file.
- Handles load-immediate, branch-on-zero and halt; sits between the instruction ROM, register file and ALU at the processor top level.

Parameters:
- PC_W, 4, program counter / instruction address width; PC wraps modulo 2^PC_W.
- INSTR_W, 12, instruction width; fixed field layout below, must be 12.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  begin execution from pc=0; sampled only in IDLE or HALTED
- instr_addr  output  PC_W  ROM address (= pc)
- instr_data  input  INSTR_W  ROM data, combinational read of instr_addr
- rs1_addr  output  2  register-file read port 1 address (ALU operand1)
- rs2_addr  output  2  register-file read port 2 address (ALU operand2)
- rf_we  output  1  register-file write strobe
- rf_waddr  output  2  write address
- rf_wdata  output  4  write data
- alu_op  output  4  ALU operation code
- alu_result  input  4  ALU registered result
- alu_zero  input  1  ALU registered zero flag
- alu_carry  input  1  ALU registered carry flag
- alu_we  input  1  ALU write-enable (0 for undefined ALU ops)
- busy  output  1  high in FETCH/EXECUTE/WRITEBACK
- halted  output  1  high in HALTED
- z_flag  output  1  latched zero flag
- c_flag  output  1  latched carry flag

Behaviour:
- Instruction fields:
  - op = [11:8], rd = [7:6], rs1 = [5:4], rs2 = [3:2]
  - imm = [5:2] (LDI); target = [PC_W-1:0] (BZ)
- Opcode map: 0000-1010 ALU ops (passed unchanged to alu_op); 1011 LDI; 1100 BZ; 1101/1110 NOP; 1111 HALT.
- States: IDLE, FETCH, EXECUTE, WRITEBACK, HALTED; encoding in package.
- Reset: state=IDLE, pc=0, IR=0, z_flag=0, c_flag=0. All outputs 0 except instr_addr=pc=0.
- IDLE --start--> FETCH with pc=0. HALTED --start--> FETCH with pc=0, flags cleared.
- FETCH (1 cycle): IR <= instr_data; go to EXECUTE.
- EXECUTE (1 cycle):
  - ALU op: alu_op=IR.op, rs1_addr/rs2_addr from IR. The ALU captures at the end of this cycle. Go to WRITEBACK.
  - LDI: rf_we=1, rf_waddr=rd, rf_wdata=imm; pc<=pc+1; go to FETCH.
  - BZ: pc <= z_flag ? target : pc+1; go to FETCH.
  - NOP: pc<=pc+1; go to FETCH.
  - HALT: pc unchanged; go to HALTED.
- WRITEBACK (1 cycle):
  - rf_we=alu_we, rf_waddr=rd, rf_wdata=alu_result.
  - z_flag<=alu_zero, c_flag<=alu_carry (updated even when alu_we=0).
  - pc<=pc+1; go to FETCH.
- alu_op, rs1_addr, rs2_addr hold IR values in EXECUTE and WRITEBACK; 0 elsewhere. They must stay stable across the ALU capture edge.
- rf_we is a Moore output: high for exactly one cycle per write; never high in IDLE, FETCH or HALTED.
- Latency: ALU instruction 3 cycles; LDI, BZ and NOP 2 cycles; HALT 2 cycles to halted=1.
- pc+1 and BZ target wrap modulo 2^PC_W; pc=2^PC_W-1 followed by a non-branch gives pc=0.
- start is ignored while busy.
- rst has priority over everything. Reset mid-instruction aborts with no rf_we pulse in the following cycle.
- Flags are never modified by LDI, BZ, NOP or HALT.

Decomposition:
- Package alu_seq_pkg:
  - state enum
  - opcode constants (OP_ADD..OP_SHL, OP_LDI, OP_BZ, OP_HALT)
  - field position constants
- Sub-module alu_seq_decode: combinational decode of IR into is_alu, is_ldi, is_bz, is_halt, rd, rs1, rs2, imm, target.
- FSM, pc and flags stay in the top module.

Test Plan:
- Reset, then start with ROM {0: LDI r1,5; 1: LDI r2,3; 2: ADD r3,r1,r2; 3: HALT}:
  - rf_we pulses write r1=5, r2=3, then r3=8 in the WRITEBACK of instr 2.
  - halted=1 at cycle 9 after start.
  - z_flag=0, c_flag=0.
- LDI r1,15; LDI r2,1; ADD r0,r1,r2 -> rf_wdata=0, c_flag=1, z_flag=1.
- Branch on zero:
  - SUB r3,r1,r1 then BZ target=7 -> next instr_addr=7.
  - With z_flag=0 the same BZ -> instr_addr=pc+1.
- Opcode 1101 (NOP) and 1110: no rf_we, flags unchanged, 2 cycles each, pc advances by 1.
- pc=15 executing NOP -> next fetch at instr_addr=0.
- Assert rst during WRITEBACK of an ADD -> next cycle rf_we=0, state IDLE, pc=0. Start pulsed while busy has no effect.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, opcode map and
// instruction field positions.
package alu_seq_pkg;

    localparam int unsigned IR_W   = 12;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned RA_W   = 2;
    localparam int unsigned DATA_W = 4;

    // LSB positions of the fixed-layout instruction fields
    localparam int unsigned OP_LSB  = 8;
    localparam int unsigned RD_LSB  = 6;
    localparam int unsigned RS1_LSB = 4;
    localparam int unsigned RS2_LSB = 2;
    localparam int unsigned IMM_LSB = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALTED    = 3'd4
    } state_e;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h2;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h3;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h4;
    localparam logic [OPC_W-1:0] OP_NOT  = 4'h5;
    localparam logic [OPC_W-1:0] OP_INC  = 4'h6;
    localparam logic [OPC_W-1:0] OP_DEC  = 4'h7;
    localparam logic [OPC_W-1:0] OP_PASS = 4'h8;
    localparam logic [OPC_W-1:0] OP_SHR  = 4'h9;
    localparam logic [OPC_W-1:0] OP_SHL  = 4'hA;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'hB;
    localparam logic [OPC_W-1:0] OP_BZ   = 4'hC;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: splits the IR into class strobes and fields.
module alu_seq_decode
    import alu_seq_pkg::*;
#(
    parameter int unsigned PC_W = 4
) (
    input  logic [IR_W-1:0]   ir,
    output logic              is_alu,
    output logic              is_ldi,
    output logic              is_bz,
    output logic              is_halt,
    output logic [OPC_W-1:0]  op,
    output logic [RA_W-1:0]   rd,
    output logic [RA_W-1:0]   rs1,
    output logic [RA_W-1:0]   rs2,
    output logic [DATA_W-1:0] imm,
    output logic [PC_W-1:0]   target
);

    always_comb begin
        op      = ir[OP_LSB +: OPC_W];
        rd      = ir[RD_LSB +: RA_W];
        rs1     = ir[RS1_LSB +: RA_W];
        rs2     = ir[RS2_LSB +: RA_W];
        imm     = ir[IMM_LSB +: DATA_W];
        target  = ir[PC_W-1:0];
        is_alu  = (op <= OP_SHL);
        is_ldi  = (op == OP_LDI);
        is_bz   = (op == OP_BZ);
        is_halt = (op == OP_HALT);
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for the 4-bit ALU: fetch/decode from ROM, drive the
// ALU and register file, handle LDI, branch-on-zero and halt.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned PC_W    = 4,
    parameter int unsigned INSTR_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [PC_W-1:0]    instr_addr,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [1:0]         rs1_addr,
    output logic [1:0]         rs2_addr,
    output logic               rf_we,
    output logic [1:0]         rf_waddr,
    output logic [3:0]         rf_wdata,
    output logic [3:0]         alu_op,
    input  logic [3:0]         alu_result,
    input  logic               alu_zero,
    input  logic               alu_carry,
    input  logic               alu_we,
    output logic               busy,
    output logic               halted,
    output logic               z_flag,
    output logic               c_flag
);

    state_e              state, state_next;
    logic [PC_W-1:0]     pc, pc_next, pc_inc;
    logic [INSTR_W-1:0]  ir, ir_next;
    logic                z_next, c_next;

    logic                is_alu, is_ldi, is_bz, is_halt;
    logic [OPC_W-1:0]    dec_op;
    logic [RA_W-1:0]     dec_rd, dec_rs1, dec_rs2;
    logic [DATA_W-1:0]   dec_imm;
    logic [PC_W-1:0]     dec_target;

    alu_seq_decode #(.PC_W(PC_W)) u_decode (
        .ir      (ir),
        .is_alu  (is_alu),
        .is_ldi  (is_ldi),
        .is_bz   (is_bz),
        .is_halt (is_halt),
        .op      (dec_op),
        .rd      (dec_rd),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .imm     (dec_imm),
        .target  (dec_target)
    );

    assign instr_addr = pc;
    assign pc_inc     = pc + PC_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            pc     <= '0;
            ir     <= '0;
            z_flag <= 1'b0;
            c_flag <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            ir     <= ir_next;
            z_flag <= z_next;
            c_flag <= c_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        z_next     = z_flag;
        c_next     = c_flag;
        alu_op     = '0;
        rs1_addr   = '0;
        rs2_addr   = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        busy       = 1'b0;
        halted     = 1'b0;

        // ALU operands held steady across the capture edge into WRITEBACK
        if (state == ST_EXECUTE || state == ST_WRITEBACK) begin
            alu_op   = dec_op;
            rs1_addr = dec_rs1;
            rs2_addr = dec_rs2;
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FETCH;
                    pc_next    = '0;
                end
            end
            ST_FETCH: begin
                busy       = 1'b1;
                ir_next    = instr_data;
                state_next = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                busy = 1'b1;
                if (is_alu) begin
                    state_next = ST_WRITEBACK;
                end else if (is_ldi) begin
                    rf_we      = 1'b1;
                    rf_waddr   = dec_rd;
                    rf_wdata   = dec_imm;
                    pc_next    = pc_inc;
                    state_next = ST_FETCH;
                end else if (is_bz) begin
                    pc_next    = z_flag ? dec_target : pc_inc;
                    state_next = ST_FETCH;
                end else if (is_halt) begin
                    state_next = ST_HALTED;
                end else begin
                    pc_next    = pc_inc;
                    state_next = ST_FETCH;
                end
            end
            ST_WRITEBACK: begin
                busy       = 1'b1;
                rf_we      = alu_we;
                rf_waddr   = dec_rd;
                rf_wdata   = alu_result;
                z_next     = alu_zero;
                c_next     = alu_carry;
                pc_next    = pc_inc;
                state_next = ST_FETCH;
            end
            ST_HALTED: begin
                halted = 1'b1;
                if (start) begin
                    state_next = ST_FETCH;
                    pc_next    = '0;
                    z_next     = 1'b0;
                    c_next     = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
